rwt_tag_insert: RTL
===================

# rwt_tag_insert

Stream tag inserter for the receive (ADC → DMA) path; the framing encoder matching `rwt_tag_extract` on the transmit path. It accepts 64-bit user samples with an optional per-beat tag, and emits a 64-bit AXI-stream toward the DMA async FIFO. Each tag is encoded in-band as an escape word followed by a control word. Data words that collide with the escape word are escaped. It sits between the user ADC-side logic and the ADC→DMA `util_axis_fifo`.

## Interface
- No parameters; data width fixed at 64, tag type width fixed at 7.
- `clk`  in  1  stream clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `use_tags`  in  1  1 = encode tags and escapes; 0 = raw pass-through.
- `tag_escape`  in  64  escape word; quasi-static.
- `s_axi_valid`  in  1  input beat valid.
- `s_axi_ready`  out  1  input beat accepted when `valid & ready`.
- `s_axi_data`  in  64  input sample word.
- `s_axi_tag_valid`  in  1  this beat carries a tag.
- `s_axi_tag_type`  in  7  tag type.
- `s_axi_last`  in  1  end of packet.
- `m_axi_valid`  out  1  output beat valid (registered).
- `m_axi_ready`  in  1  downstream ready.
- `m_axi_data`  out  64  output word (registered).
- `m_axi_last`  out  1  end of packet (registered).
- `tag_count`, `escape_count`  out  32 each  only with `RWT_TAG_INSERT_STATS_EN`.

## Operation
- **Control word (CW):** tag CW = `{56'd0, 1'b1, tag_type[6:0]}`; literal CW = 64'd0.
- **Input beat expansion with `use_tags=1`,** in output order:
  - if `tag_valid`: `ESC`, then tag CW;
  - then, if `data == tag_escape`: `ESC`, then literal CW;
  - otherwise: `data`.
  - A beat therefore produces 1–4 output words.
- **Input beat with `use_tags=0`:** exactly 1 output word equal to `data`; tag fields ignored; no escaping.
- `m_axi_last` is asserted only on the final output word of a beat whose `s_axi_last=1`. It is 0 on all ESC and CW words.
- `tag_escape`, `use_tags`, data and tag fields are captured into a hold register at acceptance. Changes afterwards do not affect a beat already in expansion.
- **FSM states:**
  - `IDLE`: accepting. On accept go to `TAG_ESC` if a tag is present (tags enabled). Else go to `LIT_ESC` on an escape collision. Else the word is written straight to the output and the FSM stays in `IDLE`.
  - `TAG_ESC` → `TAG_CW`.
  - `TAG_CW` → `LIT_ESC` if escape collision, else `DATA`.
  - `LIT_ESC` → `LIT_CW`.
  - `LIT_CW` → `IDLE`.
  - `DATA` → `IDLE`.
  - Each transition occurs only when the output register loads, i.e. `~m_axi_valid | m_axi_ready`.
- `s_axi_ready = (state == IDLE) & (~m_axi_valid | m_axi_ready)`. It is combinational from `m_axi_ready`.
- A tag with type 0 is legal; the CW still has bit 7 set.

## Timing
- **Reset values:** `m_axi_valid=0`, `m_axi_data=0`, `m_axi_last=0`, state = `IDLE`, counters = 0. `s_axi_ready` is 1 after reset, since the output register is empty.
- **Latency:** first output word is valid 1 cycle after acceptance.
- **Throughput:**
  - Untagged, non-colliding beats run at 1 beat/cycle with `m_axi_ready` held high.
  - A beat expanding to N words blocks input for N−1 further cycles.
- **Output handshake:** `m_axi_data`, `m_axi_valid` and `m_axi_last` stay stable while `m_axi_valid & ~m_axi_ready`.
- **Simultaneous events:** output drain and input accept in the same cycle are legal; the output register reloads with no bubble.
- **Reset mid-expansion:** the partially emitted beat is discarded. No further words of it appear after `rst` deasserts.
- **Counters:** wrap modulo 2^32.

## Configuration
- **`RWT_TAG_INSERT_STATS_EN` defined:** adds outputs `tag_count` and `escape_count`.
  - `tag_count` increments once per emitted tag CW.
  - `escape_count` increments once per emitted literal CW.
  - Both are counted at the output handshake.
- **Not defined:** those ports and counters are absent; all other behaviour is identical.

## Test plan
- **Raw pass-through:** `use_tags=0`; send data 1..8 with `tag_valid=1` and `last` on word 8, `m_axi_ready=1`. Expect output 1..8 one per cycle, `last` on 8, no ESC words.
- **Tag:** `use_tags=1`, escape `0xAAAAAAAAAAAAAAAA`; beat data `0x1234`, `tag_type=0x05`, `last=1`. Expect `0xAAAA…AA`, `0x85`, `0x1234(last)`; `s_axi_ready` low for 2 cycles.
- **Collision plus tag:** data = escape with `tag_type=0x7F`. Expect `ESC`, `0xFF`, `ESC`, `0x0`; `last` on the final word only.
- **Backpressure:** toggle `m_axi_ready` randomly over 1000 random beats (10% tags, 5% collisions). A reference decoder must recover the identical beats and tags, and held output must not change while stalled.
- **Reset during expansion:** assert `rst` after the first ESC word of a tagged beat. Outputs go to 0 immediately; the next beat after reset emits cleanly from `IDLE`.
- **Stats build:** with the macro defined, run the tag and collision scenarios. Expect `tag_count=2` and `escape_count=1`.

Source files
------------

// File: rtl/rwt_tag_insert.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rwt_tag_insert: receive-path stream tag inserter. Encodes per-beat tags as |
// | ESC + control word, escapes data words equal to ESC. Optional statistics  |
// | counters enabled by defining RWT_TAG_INSERT_STATS_EN.                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rwt_tag_insert (
  input  logic        clk,
  input  logic        rst,
  input  logic        use_tags,
  input  logic [63:0] tag_escape,
  input  logic        s_axi_valid,
  output logic        s_axi_ready,
  input  logic [63:0] s_axi_data,
  input  logic        s_axi_tag_valid,
  input  logic [6:0]  s_axi_tag_type,
  input  logic        s_axi_last,
  output logic        m_axi_valid,
  input  logic        m_axi_ready,
  output logic [63:0] m_axi_data,
  output logic        m_axi_last
`ifdef RWT_TAG_INSERT_STATS_EN
  ,
  output logic [31:0] tag_count,
  output logic [31:0] escape_count
`endif
);

  // Each state names the word the output register loads next; the first word
  // of a beat is loaded straight from IDLE, so a beat of N words blocks N-1 cycles.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TAG_CW  = 3'd1,
    S_LIT_ESC = 3'd2,
    S_LIT_CW  = 3'd3,
    S_DATA    = 3'd4
  } state_t;

  state_t      r_state;
  logic [63:0] r_data;
  logic [63:0] r_esc;
  logic [6:0]  r_tag_type;
  logic        r_coll;
  logic        r_last;

  logic        w_load;
  logic        w_tag;
  logic        w_coll;

  assign w_load      = ~m_axi_valid | m_axi_ready;
  assign s_axi_ready = (r_state == S_IDLE) & w_load;
  assign w_tag       = use_tags & s_axi_tag_valid;
  assign w_coll      = use_tags & (s_axi_data == tag_escape);

`ifdef RWT_TAG_INSERT_STATS_EN
  logic r_is_tag_cw;
  logic r_is_lit_cw;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      m_axi_valid <= 1'b0;
      m_axi_data  <= 64'd0;
      m_axi_last  <= 1'b0;
      r_data      <= 64'd0;
      r_esc       <= 64'd0;
      r_tag_type  <= 7'd0;
      r_coll      <= 1'b0;
      r_last      <= 1'b0;
`ifdef RWT_TAG_INSERT_STATS_EN
      r_is_tag_cw <= 1'b0;
      r_is_lit_cw <= 1'b0;
`endif
    end else if (w_load) begin
`ifdef RWT_TAG_INSERT_STATS_EN
      r_is_tag_cw <= 1'b0;
      r_is_lit_cw <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (s_axi_valid) begin
            r_data      <= s_axi_data;
            r_esc       <= tag_escape;
            r_tag_type  <= s_axi_tag_type;
            r_coll      <= w_coll;
            r_last      <= s_axi_last;
            m_axi_valid <= 1'b1;
            if (w_tag) begin
              m_axi_data <= tag_escape;
              m_axi_last <= 1'b0;
              r_state    <= S_TAG_CW;
            end else if (w_coll) begin
              m_axi_data <= tag_escape;
              m_axi_last <= 1'b0;
              r_state    <= S_LIT_CW;
            end else begin
              m_axi_data <= s_axi_data;
              m_axi_last <= s_axi_last;
            end
          end else begin
            m_axi_valid <= 1'b0;
          end
        end
        S_TAG_CW: begin
          m_axi_valid <= 1'b1;
          m_axi_data  <= {56'd0, 1'b1, r_tag_type};
          m_axi_last  <= 1'b0;
`ifdef RWT_TAG_INSERT_STATS_EN
          r_is_tag_cw <= 1'b1;
`endif
          r_state     <= r_coll ? S_LIT_ESC : S_DATA;
        end
        S_LIT_ESC: begin
          m_axi_valid <= 1'b1;
          m_axi_data  <= r_esc;
          m_axi_last  <= 1'b0;
          r_state     <= S_LIT_CW;
        end
        S_LIT_CW: begin
          m_axi_valid <= 1'b1;
          m_axi_data  <= 64'd0;
          m_axi_last  <= r_last;
`ifdef RWT_TAG_INSERT_STATS_EN
          r_is_lit_cw <= 1'b1;
`endif
          r_state     <= S_IDLE;
        end
        S_DATA: begin
          m_axi_valid <= 1'b1;
          m_axi_data  <= r_data;
          m_axi_last  <= r_last;
          r_state     <= S_IDLE;
        end
        default: begin
          m_axi_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

`ifdef RWT_TAG_INSERT_STATS_EN
  // Counted when the control word actually leaves, not when it is loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_count    <= 32'd0;
      escape_count <= 32'd0;
    end else if (m_axi_valid & m_axi_ready) begin
      if (r_is_tag_cw) tag_count    <= tag_count + 32'd1;
      if (r_is_lit_cw) escape_count <= escape_count + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire
